// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction store with a single-cycle fetch port and a load port.
// After reset the store is swept to zero (one word per cycle). Once the
// sweep is done, the block accepts loads and fetches. A load has priority
// over a fetch in the same cycle.
//
// Ports
//   CLK          system clock, all state updates on the rising edge
//   RESET        synchronous, active-high reset
//   PC           byte address of the requested 16-bit instruction
//   pc_valid     fetch request qualifier
//   pc_ready     fetch accepted this cycle when pc_valid is also high
//   instruction  fetched word, registered, held until the next fetch
//   instr_valid  one-cycle pulse marking a new instruction
//   fault        registered; misaligned or out-of-range fetch
//   load_en      write strobe for the instruction store
//   load_addr    word index to write
//   load_data    word to write
//   busy         high while the store is being cleared
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [31:0]   PC,
    input  logic          pc_valid,
    output logic          pc_ready,
    output logic [15:0]   instruction,
    output logic          instr_valid,
    output logic          fault,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [15:0]   load_data,
    output logic          busy
);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    logic [15:0]   instruction_q, instruction_d;
    logic          fault_q, fault_d;
    logic          instr_valid_q, instr_valid_d;
    logic          busy_q, busy_d;

    logic [15:0]   mem_q [DEPTH];
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [15:0]   mem_wdata;

    logic          accept;
    logic          bad_pc;
    logic [AW-1:0] widx;
    logic [15:0]   rd_word;

    // Fetch is only possible in RUN and only when no load competes.
    assign pc_ready = (state_q == S_RUN) && !load_en;
    assign accept   = pc_valid && pc_ready;

    // PC is a byte address of 2-byte instructions: bit 0 must be clear and
    // everything above the word index must be zero.
    assign widx    = PC[AW:1];
    assign bad_pc  = PC[0] || (|PC[31:AW+1]);
    assign rd_word = mem_q[widx];

    always_comb begin
        state_d       = state_q;
        clr_cnt_d     = clr_cnt_q;
        instruction_d = instruction_q;
        fault_d       = fault_q;
        instr_valid_d = 1'b0;
        mem_we        = 1'b0;
        mem_waddr     = load_addr;
        mem_wdata     = load_data;

        case (state_q)
            S_CLEAR: begin
                // Sweep one word per cycle; loads are ignored here.
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wdata = 16'h0000;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == AW'(DEPTH - 1)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (load_en) begin
                    mem_we = 1'b1;
                end
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase

        // The read happens before any write at this edge; load and fetch
        // never coincide, so a fetch always sees loads from earlier edges.
        if (accept) begin
            instr_valid_d = 1'b1;
            fault_d       = bad_pc;
            instruction_d = bad_pc ? 16'h0000 : rd_word;
        end

        busy_d = (state_d == S_CLEAR);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= S_CLEAR;
            clr_cnt_q     <= '0;
            instruction_q <= 16'h0000;
            fault_q       <= 1'b0;
            instr_valid_q <= 1'b0;
            busy_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            clr_cnt_q     <= clr_cnt_d;
            instruction_q <= instruction_d;
            fault_q       <= fault_d;
            instr_valid_q <= instr_valid_d;
            busy_q        <= busy_d;
        end
    end

    // Storage array carries no reset; the CLEAR sweep initialises it.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign instruction = instruction_q;
    assign fault       = fault_q;
    assign instr_valid = instr_valid_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Self-checking bench for instr_fetch. A behavioural model (array store,
// remaining-clear-cycles counter, expected output registers) tracks what the
// outputs must be every cycle; directed steps cover the named scenarios and a
// randomized phase follows.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [31:0]   PC;
    logic          pc_valid;
    logic          pc_ready;
    logic [15:0]   instruction;
    logic          instr_valid;
    logic          fault;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [15:0]   load_data;
    logic          busy;

    instr_fetch #(.DEPTH(DEPTH), .AW(AW)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .PC          (PC),
        .pc_valid    (pc_valid),
        .pc_ready    (pc_ready),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .fault       (fault),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .busy        (busy)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] m_mem [DEPTH];
    bit          m_known      = 1'b0;
    int          m_clear_left = 0;
    logic [15:0] m_instr      = 16'h0000;
    logic        m_fault      = 1'b0;
    logic        m_valid      = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check combinational/pre-edge outputs,
    // advance the model across the edge, then check registered outputs.
    task automatic cyc(input bit rst, input bit le, input logic [AW-1:0] la,
                       input logic [15:0] ld, input bit pv, input logic [31:0] pc);
        bit   bad;
        RESET     = rst;
        load_en   = le;
        load_addr = la;
        load_data = ld;
        pc_valid  = pv;
        PC        = pc;
        #1;
        if (m_known) begin
            chk("busy", {31'd0, busy}, {31'd0, m_clear_left > 0});
            chk("pc_ready", {31'd0, pc_ready}, {31'd0, (m_clear_left == 0) && !le});
        end
        @(posedge CLK);
        if (rst) begin
            m_known      = 1'b1;
            m_clear_left = DEPTH;
            m_instr      = 16'h0000;
            m_fault      = 1'b0;
            m_valid      = 1'b0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = 16'h0000;
        end else if (m_known) begin
            if (m_clear_left > 0) begin
                m_clear_left--;
                m_valid = 1'b0;
            end else if (le) begin
                m_mem[la] = ld;
                m_valid   = 1'b0;
            end else if (pv) begin
                bad     = (pc % 2 != 0) || (pc >= 2 * DEPTH);
                m_instr = bad ? 16'h0000 : m_mem[pc / 2];
                m_fault = bad;
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
        if (m_known) begin
            chk("instruction", {16'd0, instruction}, {16'd0, m_instr});
            chk("fault", {31'd0, fault}, {31'd0, m_fault});
            chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
        end
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, '0, 16'h0000, 1'b0, 32'h0);
    endtask

    task automatic fetch(input logic [31:0] pc);
        cyc(1'b0, 1'b0, '0, 16'h0000, 1'b1, pc);
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [15:0] d);
        cyc(1'b0, 1'b1, a, d, 1'b0, 32'h0);
    endtask

    task automatic count_busy(input string tag);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            idle();
            n++;
        end
        chk(tag, n, DEPTH);
    endtask

    initial begin
        int sel;
        logic [31:0] rpc;

        RESET = 1'b0; PC = '0; pc_valid = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        @(negedge CLK);

        // Reset pulse and clear sweep
        cyc(1'b1, 1'b0, '0, 16'h0000, 1'b0, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        count_busy("busy_len_initial");
        RESET = 1'b0; load_en = 1'b0; pc_valid = 1'b0; #1;
        chk("ready_after_clear", {31'd0, pc_ready}, 32'd1);

        fetch(32'h0);
        chk("fetch0_instr", {16'd0, instruction}, 32'h0000);
        chk("fetch0_fault", {31'd0, fault}, 32'd0);

        // Load then fetch of the same word
        load(6'd5, 16'hA3C1);
        fetch(32'h0A);
        chk("fetch0a_instr", {16'd0, instruction}, 32'hA3C1);
        chk("fetch0a_valid", {31'd0, instr_valid}, 32'd1);
        idle();
        chk("pulse_one_cycle", {31'd0, instr_valid}, 32'd0);
        chk("instr_held", {16'd0, instruction}, 32'hA3C1);

        // Faults
        fetch(32'h0B);
        chk("misalign_fault", {31'd0, fault}, 32'd1);
        chk("misalign_instr", {16'd0, instruction}, 32'h0000);
        fetch(32'h80);
        chk("range_fault", {31'd0, fault}, 32'd1);
        chk("range_instr", {16'd0, instruction}, 32'h0000);

        // Load beats fetch; held request accepted next cycle
        cyc(1'b0, 1'b1, 6'd7, 16'hBEEF, 1'b1, 32'h0E);
        chk("collide_no_valid", {31'd0, instr_valid}, 32'd0);
        fetch(32'h0E);
        chk("held_valid", {31'd0, instr_valid}, 32'd1);
        chk("held_instr", {16'd0, instruction}, 32'hBEEF);

        // Back-to-back fetches
        load(6'd0, 16'h1111);
        load(6'd1, 16'h2222);
        load(6'd2, 16'h3333);
        fetch(32'h0);
        chk("b2b_0", {15'd0, instr_valid, instruction}, 32'h1_1111);
        fetch(32'h2);
        chk("b2b_1", {15'd0, instr_valid, instruction}, 32'h1_2222);
        fetch(32'h4);
        chk("b2b_2", {15'd0, instr_valid, instruction}, 32'h1_3333);

        // Reset in the middle of the clear sweep
        cyc(1'b1, 1'b0, '0, 16'h0000, 1'b0, 32'h0);
        for (int i = 0; i < 30; i++) idle();
        cyc(1'b1, 1'b0, '0, 16'h0000, 1'b0, 32'h0);
        count_busy("busy_len_restart");

        // Reset coinciding with an accepted fetch
        load(6'd5, 16'h5A5A);
        cyc(1'b1, 1'b0, '0, 16'h0000, 1'b1, 32'h0A);
        chk("rst_fetch_no_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_fetch_instr", {16'd0, instruction}, 32'h0000);
        count_busy("busy_len_after_fetch_rst");

        // Randomized phase
        for (int i = 0; i < 600; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7)       rpc = 32'($urandom_range(0, DEPTH - 1)) * 2;
            else if (sel == 7) rpc = 32'($urandom_range(0, 2 * DEPTH - 1)) | 32'h1;
            else if (sel == 8) rpc = $urandom_range(2 * DEPTH, 32'hFFFF_FFF0) & ~32'h1;
            else               rpc = 32'h8000_0000 | 32'($urandom_range(0, 2 * DEPTH - 1));
            cyc(($urandom_range(0, 249) == 0),
                ($urandom_range(0, 9) < 3),
                AW'($urandom_range(0, DEPTH - 1)),
                16'($urandom),
                ($urandom_range(0, 9) < 6),
                rpc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter DEPTH, default 64, SHALL set the number of 16-bit instruction words stored.
REQ-002 Parameter AW, default 6, SHALL set the word-index width, with DEPTH = 2**AW.
REQ-003 The module SHALL have one clock and one reset, with ports as listed below.
REQ-004 CLK  input  1  system clock; all state SHALL update on its rising edge.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 PC  input  32  byte address of the requested instruction.
REQ-007 pc_valid  input  1  fetch request qualifier for PC.
REQ-008 pc_ready  output  1  fetch request accepted this cycle when pc_valid is also high.
REQ-009 instruction  output  16  fetched instruction word, registered.
REQ-010 instr_valid  output  1  one-cycle pulse marking a new instruction.
REQ-011 fault  output  1  registered; set together with instr_valid when the fetched PC is misaligned or out of range.
REQ-012 load_en  input  1  write strobe for the instruction store.
REQ-013 load_addr  input  AW  word index to write.
REQ-014 load_data  input  16  instruction word to write.
REQ-015 busy  output  1  high while the store is being cleared.

Function
REQ-016 The FSM SHALL have exactly two states: CLEAR and RUN.
REQ-017 CLEAR SHALL write 16'h0000 to word clr_cnt each cycle, with clr_cnt running 0 to DEPTH-1.
REQ-018 CLEAR SHALL go to RUN in the cycle after word DEPTH-1 is written, so CLEAR lasts exactly DEPTH cycles.
REQ-019 In CLEAR, busy=1, pc_ready=0, and load_en SHALL be ignored.
REQ-020 In RUN, busy=0.
REQ-021 In RUN, pc_ready SHALL equal !load_en, so load has priority over fetch.
REQ-022 In RUN, load_en=1 SHALL write load_data to word load_addr at that clock edge.
REQ-023 A fetch is accepted when pc_valid and pc_ready are both high in cycle N.
REQ-024 An accepted fetch SHALL drive instruction and fault in cycle N+1 and pulse instr_valid=1 in cycle N+1 only, giving latency 1.
REQ-025 Back-to-back accepted fetches SHALL give one result per cycle, giving throughput 1.
REQ-026 Word index SHALL be PC[AW:1]; PC is a byte address of 2-byte instructions.
REQ-027 PC[0]=1 is misaligned: the fetch SHALL return instruction=16'h0000 with fault=1.
REQ-028 Any nonzero bit in PC[31:AW+1] is out of range: the fetch SHALL return instruction=16'h0000 with fault=1.
REQ-029 A valid, aligned, in-range fetch SHALL return the stored word with fault=0.
REQ-030 instruction and fault SHALL hold their value until the next accepted fetch.
REQ-031 When no fetch is accepted in cycle N, instr_valid SHALL be 0 in cycle N+1.
REQ-032 A fetch accepted in cycle N SHALL return the word as stored after all edges up to and including cycle N-1; a load to the same word in cycle N-1 SHALL be visible.
REQ-033 pc_valid while pc_ready=0 SHALL be dropped; the requester SHALL hold PC and pc_valid until acceptance.
REQ-034 A load_addr at or beyond DEPTH is impossible by construction, since the address is AW bits wide.

Reset
REQ-035 RESET=1 at an edge SHALL set the state to CLEAR and clr_cnt to 0.
REQ-036 RESET=1 at an edge SHALL set instruction=16'h0000, instr_valid=0, and fault=0.
REQ-037 With RESET=1, busy SHALL read 1 and pc_ready SHALL read 0 from the cycle after that edge.
REQ-038 RESET asserted during CLEAR SHALL restart the sweep at word 0.
REQ-039 RESET asserted during RUN SHALL discard any in-flight fetch result; no instr_valid SHALL follow.
REQ-040 After RESET deasserts, busy SHALL stay 1 for exactly DEPTH cycles.

Verification
REQ-041 Bench SHALL check: RESET pulse, then wait -> busy=1 for exactly 64 cycles, then pc_ready=1; fetch PC=0x0 -> instruction=16'h0000, fault=0.
REQ-042 Bench SHALL check: load word 5 = 16'hA3C1, then fetch PC=0x0A next cycle -> instruction=16'hA3C1, instr_valid pulse one cycle later, fault=0.
REQ-043 Bench SHALL check: fetch PC=0x0B -> fault=1 and instruction=16'h0000; then fetch PC=0x80 -> fault=1 and instruction=16'h0000.
REQ-044 Bench SHALL check: load_en=1 and pc_valid=1 in the same cycle -> pc_ready=0 and no instr_valid next cycle; the held request is accepted the following cycle.
REQ-045 Bench SHALL check: back-to-back fetches PC=0x0, 0x2, 0x4 after loading 16'h1111, 16'h2222, 16'h3333 -> three consecutive instr_valid cycles returning those values in order.
REQ-046 Bench SHALL check: RESET during CLEAR at clr_cnt=30 -> busy stays 1 for 64 more cycles; RESET in the same cycle as an accepted fetch -> no instr_valid afterwards.
